// File: rtl/sweep_peak_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sweep_peak_tracker_pkg
// Description : Shared types and constants for the sweep peak tracker:
//               FSM state encoding, ADC sample width, the bit range used
//               for the peak comparison, and the sample counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package sweep_peak_tracker_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int c_adc_w   = 10;
    // Only the upper six ADC bits take part in the peak decision; the low
    // nibble is treated as noise.
    localparam int c_cmp_msb = 9;
    localparam int c_cmp_lsb = 4;
    localparam int c_cnt_w   = 10;

endpackage : sweep_peak_tracker_pkg
`default_nettype wire

// File: rtl/voltage_comparator.sv
`default_nettype none
// ============================================================================
// Module      : voltage_comparator
// Description : Combinational magnitude comparator on a bit slice of two
//               sample words. gt is high when pv[MSB:LSB] > lv[MSB:LSB].
// Ports       : pv  - present value
//               lv  - last (stored) value
//               gt  - present slice strictly greater than last slice
// Revision    : 1.0 - initial release
// ============================================================================
module voltage_comparator #(
    parameter int WIDTH = 10,
    parameter int MSB   = 9,
    parameter int LSB   = 4     // must be >= 1: the bits below LSB are ignored
) (
    input  logic [WIDTH-1:0] pv,
    input  logic [WIDTH-1:0] lv,
    output logic             gt
);

    // Bits below LSB never influence the decision.
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^{pv[LSB-1:0], lv[LSB-1:0]};

    assign gt = (pv[MSB:LSB] > lv[MSB:LSB]);

endmodule : voltage_comparator
`default_nettype wire

// File: rtl/sweep_peak_tracker.sv
`default_nettype none
// ============================================================================
// Module      : sweep_peak_tracker
// Description : Tracks the peak ADC sample (and the position at which it was
//               seen) over a sweep of N_SAMPLES accepted samples.
//               IDLE -> SWEEP on start, SWEEP -> DONE after the last sample,
//               DONE -> IDLE after a one-cycle done pulse. abort returns to
//               IDLE from SWEEP keeping the partial peak.
// Ports       : clk, rst (async, active high)
//               start, abort         - sweep control
//               adc_data, adc_valid  - sample stream
//               position             - position tagged to the current sample
//               max_value, max_pos   - captured peak and its position
//               busy                 - high in SWEEP
//               done                 - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_peak_tracker
    import sweep_peak_tracker_pkg::*;
#(
    parameter int N_SAMPLES = 180,
    parameter int POS_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [9:0]         adc_data,
    input  logic               adc_valid,
    input  logic [POS_W-1:0]   position,
    output logic [9:0]         max_value,
    output logic [POS_W-1:0]   max_pos,
    output logic               busy,
    output logic               done
);

    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(N_SAMPLES - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_adc_w-1:0]   r_max_value;
    logic [POS_W-1:0]     r_max_pos;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_gt;

    voltage_comparator #(
        .WIDTH (c_adc_w),
        .MSB   (c_cmp_msb),
        .LSB   (c_cmp_lsb)
    ) u_cmp (
        .pv (adc_data),
        .lv (r_max_value),
        .gt (w_gt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_max_value <= '0;
            r_max_pos   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    // abort has no meaning here, so start always wins.
                    if (start) begin
                        r_state     <= S_SWEEP;
                        r_busy      <= 1'b1;
                        r_count     <= '0;
                        r_max_value <= '0;
                        r_max_pos   <= '0;
                    end
                end
                S_SWEEP: begin
                    if (abort) begin
                        // A sample arriving with abort is dropped.
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (adc_valid) begin
                        // Strict greater-than: ties keep the earlier capture.
                        if (w_gt) begin
                            r_max_value <= adc_data;
                            r_max_pos   <= position;
                        end
                        r_count <= r_count + 1'b1;
                        if (r_count == c_last_cnt) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign max_value = r_max_value;
    assign max_pos   = r_max_pos;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule : sweep_peak_tracker
`default_nettype wire

// File: tb/tb_sweep_peak_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sweep_peak_tracker
// Description : Directed self-checking bench for sweep_peak_tracker with
//               N_SAMPLES = 4 and POS_W = 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sweep_peak_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] adc_data = '0;
    logic       adc_valid = 1'b0;
    logic [7:0] position = '0;
    logic [9:0] max_value;
    logic [7:0] max_pos;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    sweep_peak_tracker #(
        .N_SAMPLES (4),
        .POS_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .position  (position),
        .max_value (max_value),
        .max_pos   (max_pos),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one valid sample for a single cycle.
    task automatic send(input logic [9:0] d, input logic [7:0] p);
        adc_data  = d;
        position  = p;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic begin_sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_tests++; if (max_value !== 10'h000) begin n_fail++; $display("FAIL reset_max_value: got %h want %h", max_value, 10'h000); end
        n_tests++; if (max_pos !== 8'd0) begin n_fail++; $display("FAIL reset_max_pos: got %0d want 0", max_pos); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        begin_sweep();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
        send(10'h040, 8'd1);
        n_tests++; if (max_value !== 10'h040 || max_pos !== 8'd1) begin n_fail++; $display("FAIL basic_first: got %h@%0d want 040@1", max_value, max_pos); end
        send(10'h100, 8'd2);
        send(10'h0C0, 8'd3);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done: got %b want 0", done); end
        send(10'h050, 8'd4);
        n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done=%b busy=%b want done=1 busy=0", done, busy); end
        n_tests++; if (max_value !== 10'h100 || max_pos !== 8'd2) begin n_fail++; $display("FAIL basic_peak: got %h@%0d want 100@2", max_value, max_pos); end
        tick();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", done); end
        n_tests++; if (max_value !== 10'h100 || max_pos !== 8'd2) begin n_fail++; $display("FAIL basic_hold: got %h@%0d want 100@2", max_value, max_pos); end
    endtask

    task automatic test_tie();
        begin_sweep();
        send(10'h100, 8'd5);
        send(10'h10F, 8'd6);
        send(10'h0F0, 8'd7);
        send(10'h020, 8'd8);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL tie_done: got %b want 1", done); end
        n_tests++; if (max_value !== 10'h100 || max_pos !== 8'd5) begin n_fail++; $display("FAIL tie_keep_first: got %h@%0d want 100@5", max_value, max_pos); end
        tick();
    endtask

    task automatic test_all_low();
        // Sample offered in the start cycle must be neither captured nor counted.
        start     = 1'b1;
        adc_data  = 10'h3FF;
        position  = 8'd99;
        adc_valid = 1'b1;
        tick();
        start     = 1'b0;
        adc_valid = 1'b0;
        n_tests++; if (max_value !== 10'h000 || max_pos !== 8'd0) begin n_fail++; $display("FAIL start_cycle_sample: got %h@%0d want 000@0", max_value, max_pos); end
        for (int i = 0; i < 3; i++) send(10'h00F, 8'(i + 20));
        n_tests++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL low_count3: got done=%b busy=%b want done=0 busy=1", done, busy); end
        send(10'h00F, 8'd23);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL low_done: got %b want 1", done); end
        n_tests++; if (max_value !== 10'h000 || max_pos !== 8'd0) begin n_fail++; $display("FAIL low_peak: got %h@%0d want 000@0", max_value, max_pos); end
        tick();
    endtask

    task automatic test_abort();
        int seen_done;
        seen_done = 0;
        begin_sweep();
        send(10'h200, 8'd9);
        send(10'h010, 8'd10);
        abort     = 1'b1;
        adc_data  = 10'h3FF;
        position  = 8'd11;
        adc_valid = 1'b1;
        tick();
        abort     = 1'b0;
        adc_valid = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_tests++; if (max_value !== 10'h200 || max_pos !== 8'd9) begin n_fail++; $display("FAIL abort_partial: got %h@%0d want 200@9", max_value, max_pos); end
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) seen_done++;
            tick();
        end
        n_tests++; if (seen_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", seen_done); end
        n_tests++; if (max_value !== 10'h200 || max_pos !== 8'd9) begin n_fail++; $display("FAIL abort_hold_idle: got %h@%0d want 200@9", max_value, max_pos); end
    endtask

    task automatic test_async_reset();
        int seen_done;
        seen_done = 0;
        begin_sweep();
        send(10'h080, 8'd3);
        send(10'h090, 8'd4);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (max_value !== 10'h000 || max_pos !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got %h@%0d busy=%b done=%b want 000@0 busy=0 done=0", max_value, max_pos, busy, done);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) seen_done++;
            tick();
        end
        n_tests++; if (seen_done != 0) begin n_fail++; $display("FAIL reset_no_done: got %0d pulses want 0", seen_done); end
        // First start after reset release is honoured on the next edge.
        begin_sweep();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL post_reset_start: got busy=%b want 1", busy); end
        send(10'h010, 8'd1);
        tick();
        tick();
        send(10'h300, 8'd2);
        tick();
        send(10'h020, 8'd3);
        tick();
        tick();
        tick();
        n_tests++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL gapped_count3: got done=%b busy=%b want done=0 busy=1", done, busy); end
        send(10'h030, 8'd4);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL gapped_done: got %b want 1", done); end
        n_tests++; if (max_value !== 10'h300 || max_pos !== 8'd2) begin n_fail++; $display("FAIL gapped_peak: got %h@%0d want 300@2", max_value, max_pos); end
        tick();
    endtask

    task automatic test_start_held();
        start = 1'b1;
        tick();
        send(10'h300, 8'd7);
        send(10'h100, 8'd8);
        send(10'h110, 8'd9);
        send(10'h120, 8'd10);
        n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL held_done: got done=%b busy=%b want done=1 busy=0", done, busy); end
        tick();
        n_tests++; if (busy !== 1'b0 || done !== 1'b0 || max_value !== 10'h300) begin
            n_fail++; $display("FAIL held_idle: got busy=%b done=%b max=%h want busy=0 done=0 max=300", busy, done, max_value);
        end
        tick();
        n_tests++; if (busy !== 1'b1 || max_value !== 10'h000 || max_pos !== 8'd0) begin
            n_fail++; $display("FAIL held_restart: got busy=%b max=%h@%0d want busy=1 max=000@0", busy, max_value, max_pos);
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_all_low();
        test_abort();
        test_async_reset();
        test_start_held();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sweep_peak_tracker
`default_nettype wire
